// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back sequencer.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WR1  = 2'd1,
    WB_WR2  = 2'd2
  } wb_state_e;

  localparam logic       WB_SEL_ALU = 1'b0;
  localparam logic       WB_SEL_MEM = 1'b1;
  localparam logic [3:0] REG_ZERO   = 4'd0;

endpackage

// File: rtl/wb_sequencer.sv
// Write-back sequencer: 1-cycle registered write after accept; POI loads take two cycles and drop wb_ready for one.
// Optional same-cycle write forwarding ports are built when WB_FWD_EN is defined.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic             wb_reg_write,
  input  logic             wb_sel_mem,
  input  logic             wb_poi,
  input  logic [AW-1:0]    wb_rd,
  input  logic [AW-1:0]    wb_rs1,
  input  logic [DW-1:0]    wb_alu_result,
  input  logic [DW-1:0]    wb_mem_data,
  output logic             reg_write1,
  output logic             reg_write2,
  output logic [AW-1:0]    rf_rd,
  output logic [AW-1:0]    rf_rs1,
  output logic [DW-1:0]    Bus_W,
  output logic [CNT_W-1:0] retire_count
`ifdef WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_addr,
  output logic [DW-1:0]    fwd_data
`endif
);

  wb_state_e        state_q;
  logic             poi_pending_q;
  logic [AW-1:0]    hold_rs1_q;
  logic [DW-1:0]    hold_alu_q;

  logic             wb_ready_q;
  logic             reg_write1_q;
  logic             reg_write2_q;
  logic [AW-1:0]    rf_rd_q;
  logic [AW-1:0]    rf_rs1_q;
  logic [DW-1:0]    bus_w_q;
  logic [CNT_W-1:0] retire_count_q;
  logic [CNT_W-1:0] retire_count_d;

  logic             accept;
  logic             poi_eff;
  logic             wr1_we;
  logic [DW-1:0]    wr1_data;
  logic             retire;

  assign accept   = wb_valid && wb_ready_q;
  assign poi_eff  = wb_poi && wb_reg_write && (wb_rs1 != AW'(REG_ZERO));
  assign wr1_we   = wb_reg_write && (wb_rd != AW'(REG_ZERO));
  assign wr1_data = (wb_sel_mem == WB_SEL_ALU) ? wb_alu_result : wb_mem_data;

  // A POI retires in its second cycle; everything else retires in WR1.
  assign retire = ((state_q == WB_WR1) && !poi_pending_q) || (state_q == WB_WR2);
  assign retire_count_d = retire ? retire_count_q + CNT_W'(1) : retire_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WB_IDLE;
      poi_pending_q  <= 1'b0;
      hold_rs1_q     <= '0;
      hold_alu_q     <= '0;
      wb_ready_q     <= 1'b1;
      reg_write1_q   <= 1'b0;
      reg_write2_q   <= 1'b0;
      rf_rd_q        <= '0;
      rf_rs1_q       <= '0;
      bus_w_q        <= '0;
      retire_count_q <= '0;
    end else begin
      retire_count_q <= retire_count_d;
      if (accept) begin
        // Only the fields needed for the second write are held; WR1 outputs load directly.
        state_q       <= WB_WR1;
        poi_pending_q <= poi_eff;
        hold_rs1_q    <= wb_rs1;
        hold_alu_q    <= wb_alu_result;
        wb_ready_q    <= !poi_eff;
        reg_write1_q  <= wr1_we;
        reg_write2_q  <= 1'b0;
        rf_rd_q       <= wb_rd;
        rf_rs1_q      <= '0;
        bus_w_q       <= wr1_data;
      end else if ((state_q == WB_WR1) && poi_pending_q) begin
        state_q       <= WB_WR2;
        poi_pending_q <= 1'b0;
        wb_ready_q    <= 1'b1;
        reg_write1_q  <= 1'b0;
        reg_write2_q  <= 1'b1;
        rf_rd_q       <= '0;
        rf_rs1_q      <= hold_rs1_q;
        bus_w_q       <= hold_alu_q;
      end else begin
        state_q       <= WB_IDLE;
        poi_pending_q <= 1'b0;
        wb_ready_q    <= 1'b1;
        reg_write1_q  <= 1'b0;
        reg_write2_q  <= 1'b0;
        rf_rd_q       <= '0;
        rf_rs1_q      <= '0;
        bus_w_q       <= '0;
      end
    end
  end

  assign wb_ready     = wb_ready_q;
  assign reg_write1   = reg_write1_q;
  assign reg_write2   = reg_write2_q;
  assign rf_rd        = rf_rd_q;
  assign rf_rs1       = rf_rs1_q;
  assign Bus_W        = bus_w_q;
  assign retire_count = retire_count_q;

`ifdef WB_FWD_EN
  assign fwd_valid = reg_write1_q || reg_write2_q;
  assign fwd_addr  = reg_write2_q ? rf_rs1_q : rf_rd_q;
  assign fwd_data  = bus_w_q;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: fixed vector table, hand sequences, then random traffic against a slot-queue model.
module tb_wb_sequencer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wb_valid, wb_ready, wb_reg_write, wb_sel_mem, wb_poi;
  logic [AW-1:0]    wb_rd, wb_rs1;
  logic [DW-1:0]    wb_alu_result, wb_mem_data;
  logic             reg_write1, reg_write2;
  logic [AW-1:0]    rf_rd, rf_rs1;
  logic [DW-1:0]    Bus_W;
  logic [CNT_W-1:0] retire_count;
`ifdef WB_FWD_EN
  logic             fwd_valid;
  logic [AW-1:0]    fwd_addr;
  logic [DW-1:0]    fwd_data;
`endif

  wb_sequencer #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg_write(wb_reg_write), .wb_sel_mem(wb_sel_mem), .wb_poi(wb_poi),
    .wb_rd(wb_rd), .wb_rs1(wb_rs1),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .reg_write1(reg_write1), .reg_write2(reg_write2),
    .rf_rd(rf_rd), .rf_rs1(rf_rs1), .Bus_W(Bus_W),
    .retire_count(retire_count)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, sel, poi;
    logic [3:0]  rd, rs1;
    logic [31:0] alu, mem;
  } ins_t;

  // One expected output cycle: a register-file write slot.
  typedef struct {
    logic        we1, we2, stall, last;
    logic [3:0]  addr;
    logic [31:0] data;
  } slot_t;

  typedef struct {
    ins_t        ins;
    logic        we1, rdy1;
    logic [31:0] bus1;
    logic        we2;
    logic [31:0] bus2;
  } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  slot_t q[$];
  slot_t cur;
  logic [31:0] mcount;
  ins_t  nop;
  vec_t  tbl[7];

  function automatic slot_t idle_slot();
    slot_t s;
    s.we1 = 1'b0; s.we2 = 1'b0; s.stall = 1'b0; s.last = 1'b0;
    s.addr = '0; s.data = '0;
    return s;
  endfunction

  function automatic ins_t mk_ins(input logic rw, input logic sel, input logic poi,
                                  input logic [3:0] rd, input logic [3:0] rs1,
                                  input logic [31:0] alu, input logic [31:0] mem);
    ins_t i;
    i.rw = rw; i.sel = sel; i.poi = poi; i.rd = rd; i.rs1 = rs1; i.alu = alu; i.mem = mem;
    return i;
  endfunction

  function automatic vec_t mk(input ins_t i, input logic we1, input logic rdy1,
                              input logic [31:0] bus1, input logic we2, input logic [31:0] bus2);
    vec_t v;
    v.ins = i; v.we1 = we1; v.rdy1 = rdy1; v.bus1 = bus1; v.we2 = we2; v.bus2 = bus2;
    return v;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.rw  = ($urandom_range(0, 9) < 8);
    i.sel = 1'($urandom_range(0, 1));
    i.poi = ($urandom_range(0, 9) < 4);
    i.rd  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    case ($urandom_range(0, 4))
      0:       i.rs1 = 4'd0;
      1:       i.rs1 = i.rd;
      default: i.rs1 = 4'($urandom_range(0, 15));
    endcase
    i.alu = $urandom;
    i.mem = $urandom;
    return i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input ins_t i);
    wb_valid = vld; wb_reg_write = i.rw; wb_sel_mem = i.sel; wb_poi = i.poi;
    wb_rd = i.rd; wb_rs1 = i.rs1; wb_alu_result = i.alu; wb_mem_data = i.mem;
  endtask

  // Model: each accepted instruction becomes one or two write slots played out one per cycle.
  task automatic model_accept(input ins_t i);
    slot_t s1, s2;
    logic  eff;
    eff = i.poi && i.rw && (i.rs1 != 4'd0);
    s1 = idle_slot();
    s1.we1 = i.rw && (i.rd != 4'd0);
    s1.addr = i.rd;
    s1.data = i.sel ? i.mem : i.alu;
    s1.stall = eff;
    s1.last = !eff;
    q.push_back(s1);
    if (eff) begin
      s2 = idle_slot();
      s2.we2 = 1'b1; s2.addr = i.rs1; s2.data = i.alu; s2.last = 1'b1;
      q.push_back(s2);
    end
  endtask

  task automatic check_model();
    chk("we1", 32'(reg_write1), 32'(cur.we1));
    chk("we2", 32'(reg_write2), 32'(cur.we2));
    chk("both_we", 32'(reg_write1 && reg_write2), 32'd0);
    chk("ready", 32'(wb_ready), 32'(!cur.stall));
    chk("count", retire_count, mcount);
    if (cur.we1) begin
      chk("rf_rd", 32'(rf_rd), 32'(cur.addr));
      chk("bus_wr1", Bus_W, cur.data);
    end
    if (cur.we2) begin
      chk("rf_rs1", 32'(rf_rs1), 32'(cur.addr));
      chk("bus_wr2", Bus_W, cur.data);
    end
`ifdef WB_FWD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(cur.we1 || cur.we2));
    if (cur.we1 || cur.we2) begin
      chk("fwd_addr", 32'(fwd_addr), 32'(cur.addr));
      chk("fwd_data", fwd_data, cur.data);
    end
`endif
  endtask

  // Called #1 after a posedge: present inputs, advance one clock, compare outputs.
  task automatic tick(input logic vld, input ins_t i);
    logic acc;
    drive(vld, i);
    acc = vld && !cur.stall;
    @(posedge clk);
    if (cur.last) mcount = mcount + 32'd1;
    if (acc) model_accept(i);
    if (q.size() > 0) cur = q.pop_front();
    else cur = idle_slot();
    #1;
    check_model();
  endtask

  initial begin
    ins_t        s3[3];
    ins_t        r;
    logic        v;
    int          idx;
    int          acc_at[3];
    logic [31:0] base;

    nop = mk_ins(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0);
    drive(1'b0, nop);
    cur = idle_slot();
    mcount = '0;

    #12;
    chk("rst_we1", 32'(reg_write1), 32'd0);
    chk("rst_we2", 32'(reg_write2), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_rs1", 32'(rf_rs1), 32'd0);
    chk("rst_bus", Bus_W, 32'd0);
    chk("rst_count", retire_count, 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, nop);

    tbl[0] = mk(mk_ins(1, 0, 0, 4'd3, 4'd0, 32'h1234, 32'hDEAD), 1, 1, 32'h1234, 0, 32'h0);
    tbl[1] = mk(mk_ins(1, 1, 1, 4'd2, 4'd5, 32'h104,  32'hAAAA), 1, 0, 32'hAAAA, 1, 32'h104);
    tbl[2] = mk(mk_ins(1, 0, 0, 4'd0, 4'd0, 32'h55,   32'h66),   0, 1, 32'h55,   0, 32'h0);
    tbl[3] = mk(mk_ins(1, 1, 1, 4'd4, 4'd0, 32'h200,  32'hBEEF), 1, 1, 32'hBEEF, 0, 32'h0);
    tbl[4] = mk(mk_ins(1, 1, 1, 4'd7, 4'd7, 32'h22,   32'h11),   1, 0, 32'h11,   1, 32'h22);
    tbl[5] = mk(mk_ins(0, 0, 0, 4'd9, 4'd1, 32'h99,   32'h77),   0, 1, 32'h99,   0, 32'h0);
    tbl[6] = mk(mk_ins(0, 1, 1, 4'd6, 4'd3, 32'h300,  32'h400),  0, 1, 32'h400,  0, 32'h0);

    for (int k = 0; k < 7; k++) begin
      tick(1'b1, tbl[k].ins);
      chk("tbl_we1", 32'(reg_write1), 32'(tbl[k].we1));
      chk("tbl_rdy1", 32'(wb_ready), 32'(tbl[k].rdy1));
      chk("tbl_bus1", Bus_W, tbl[k].bus1);
      if (tbl[k].we1) chk("tbl_rd", 32'(rf_rd), 32'(tbl[k].ins.rd));
      tick(1'b0, nop);
      chk("tbl_we2", 32'(reg_write2), 32'(tbl[k].we2));
      if (tbl[k].we2) begin
        chk("tbl_rs1", 32'(rf_rs1), 32'(tbl[k].ins.rs1));
        chk("tbl_bus2", Bus_W, tbl[k].bus2);
      end
      tick(1'b0, nop);
    end
    chk("tbl_total_retired", retire_count, 32'd7);

    // ALU, POI, ALU offered back to back: the third is only taken in the WR2 cycle.
    s3[0] = mk_ins(1, 0, 0, 4'd1, 4'd0, 32'hA1, 32'h0);
    s3[1] = mk_ins(1, 1, 1, 4'd8, 4'd9, 32'hB2, 32'hC3);
    s3[2] = mk_ins(1, 0, 0, 4'd10, 4'd0, 32'hD4, 32'h0);
    base = mcount;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      logic rdy_before;
      rdy_before = wb_ready;
      if (idx < 3) tick(1'b1, s3[idx]);
      else tick(1'b0, nop);
      if (idx < 3 && rdy_before) begin
        acc_at[idx] = c;
        idx++;
      end
      if (c == 4) chk("b2b_count", retire_count, base + 32'd3);
    end
    chk("b2b_accepts", 32'(idx), 32'd3);
    chk("b2b_acc0", 32'(acc_at[0]), 32'd0);
    chk("b2b_acc1", 32'(acc_at[1]), 32'd1);
    chk("b2b_acc2", 32'(acc_at[2]), 32'd3);

    // Reset during WR1 of a POI: enables drop at once and the second write never appears.
    tick(1'b1, mk_ins(1, 1, 1, 4'd2, 4'd5, 32'h104, 32'hAAAA));
    chk("pre_rst_we1", 32'(reg_write1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we1", 32'(reg_write1), 32'd0);
    chk("midrst_we2", 32'(reg_write2), 32'd0);
    chk("midrst_ready", 32'(wb_ready), 32'd1);
    chk("midrst_count", retire_count, 32'd0);
    q.delete();
    cur = idle_slot();
    mcount = '0;
    drive(1'b0, nop);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) tick(1'b0, nop);

    v = 1'b0;
    r = nop;
    for (int c = 0; c < 3000; c++) begin
      if (!cur.stall) begin
        v = ($urandom_range(0, 9) < 7);
        r = rand_ins();
      end
      tick(v, r);
    end
    for (int c = 0; c < 3; c++) tick(1'b0, nop);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
